pc_fetch_unit: RTL

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_timeout.sv | 33 +++
 rtl/pc_fetch_unit.sv | 133 +++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and default widths for the PC fetch unit.
//   fetch_state_t : fetch FSM state encoding (IDLE / WAIT / ERR)
//   FETCH_ADDR_W  : default PC / instruction address width
//   FETCH_INSTR_W : default instruction word width
package fetch_pkg;

  localparam int FETCH_ADDR_W  = 8;
  localparam int FETCH_INSTR_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_timeout.sv
// Ack watchdog for the fetch unit.
// Counts consecutive cycles spent waiting for an instruction-memory ack and
// flags expiry on the TIMEOUT_CYC-th waiting cycle that still has no ack.
//   clk, rst : clock, synchronous active-high reset
//   run      : request outstanding (counter runs only while high)
//   ack      : memory ack this cycle (restarts the count)
//   expired  : this waiting cycle is the last one allowed
module fetch_timeout #(
  parameter int TIMEOUT_CYC = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic ack,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || !run || ack) begin
      cnt <= '0;
    end else if (cnt != LAST) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = run && !ack && (cnt == LAST);

endmodule

// File: rtl/pc_fetch_unit.sv
// PC fetch unit: issues one instruction-memory request at a time from the
// current PC, buffers the returned word for decode, and handles branch
// redirects both before issue and while a request is in flight.
// Optional ack timeout is built when FETCH_TIMEOUT_EN is defined.
//   clk, rst              : clock, synchronous active-high reset
//   pc_src, branch_target : redirect request and its target
//   stall                 : blocks issue of new requests
//   imem_req, imem_addr   : request level and held address to memory
//   imem_ack, imem_rdata  : memory response
//   instr, instr_pc,
//   instr_valid,
//   instr_ready           : one-entry output buffer to decode
//   pc                    : address of the next fetch
//   fetch_err             : sticky timeout flag (0 without the macro)
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W      = FETCH_ADDR_W,
  parameter int                INSTR_W     = FETCH_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int                TIMEOUT_CYC = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pc_src,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               stall,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [ADDR_W-1:0]  pc,
  output logic               fetch_err
);

  fetch_state_t      state_q, state_d;
  logic              issue, ack_wait, redirected, expired;
  logic              pend_q;
  logic [ADDR_W-1:0] pend_tgt_q, redir_tgt;

  // Issue only when the buffer has (or is freeing) room and no redirect is due.
  assign issue      = (state_q == IDLE) && !pc_src && !stall &&
                      (!instr_valid || instr_ready);
  assign ack_wait   = (state_q == WAIT) && imem_ack;
  // A redirect arriving in the ack cycle itself also discards that ack.
  assign redirected = pc_src || pend_q;
  assign redir_tgt  = pc_src ? branch_target : pend_tgt_q;
  assign imem_req   = (state_q == WAIT);

`ifdef FETCH_TIMEOUT_EN
  fetch_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .run     (state_q == WAIT),
    .ack     (imem_ack),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_err <= 1'b0;
    end else if (expired) begin
      fetch_err <= 1'b1;
    end
  end
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  assign expired   = 1'b0;
  assign fetch_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (issue) state_d = WAIT;
      WAIT: begin
        if (imem_ack)     state_d = IDLE;
        else if (expired) state_d = ERR;
      end
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase
  end

  // Later assignments win: an ack load overrides the handshake clear, and an
  // ack clears the pending redirect it consumes.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      imem_addr   <= RESET_PC;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      pend_q      <= 1'b0;
      pend_tgt_q  <= '0;
    end else begin
      if (instr_valid && instr_ready) instr_valid <= 1'b0;
      if (pc_src && state_q != ERR)   instr_valid <= 1'b0;
      if (issue)                      imem_addr   <= pc;
      if (state_q == IDLE && pc_src)  pc          <= branch_target;
      if (state_q == WAIT && pc_src) begin
        pend_q     <= 1'b1;
        pend_tgt_q <= branch_target;
      end
      if (ack_wait) begin
        pend_q <= 1'b0;
        if (redirected) begin
          pc <= redir_tgt;
        end else begin
          instr       <= imem_rdata;
          instr_pc    <= imem_addr;
          instr_valid <= 1'b1;
          pc          <= pc + 1'b1;
        end
      end
    end
  end

endmodule
